// File: rtl/cmp_unit_seq_if.sv
// rtl/cmp_unit_seq_if.sv - command/result bundle between the ALU sequencer and cmp_unit_seq
interface cmp_unit_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             SIGNED_MODE;
  logic             CMP_Enable;
  logic [1:0]       CMP_OUT;
  logic             CMP_flag;
  logic             CMP_Busy;

  modport master (
    output A, B, ALU_FUN, SIGNED_MODE, CMP_Enable,
    input  CMP_OUT, CMP_flag, CMP_Busy
  );

  modport slave (
    input  A, B, ALU_FUN, SIGNED_MODE, CMP_Enable,
    output CMP_OUT, CMP_flag, CMP_Busy
  );
endinterface

// File: rtl/cmp_unit_seq.sv
// rtl/cmp_unit_seq.sv - slice-serial MSB-first comparator with early exit and signed/three-way modes
module cmp_unit_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic          CLK,
  input  logic          RST,
  cmp_unit_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0]    IDX_TOP  = IW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] ONE_W    = 1;
  localparam logic [WIDTH-1:0] MSB_MASK = ONE_W << (WIDTH - 1);

  localparam logic [3:0] FN_NOP  = 4'b1000;
  localparam logic [3:0] FN_EQ   = 4'b1001;
  localparam logic [3:0] FN_GT   = 4'b1010;
  localparam logic [3:0] FN_LT   = 4'b1011;
  localparam logic [3:0] FN_CMP3 = 4'b1100;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       fun_q, fun_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       out_q, out_d;
  logic             flag_q, flag_d;
  logic [SLICE-1:0] a_sl, b_sl;

  function automatic logic [1:0] result_code(input logic [3:0] fun,
                                             input logic gt, input logic lt);
    logic eq;
    eq = !gt && !lt;
    case (fun)
      FN_EQ:   result_code = eq ? 2'd1 : 2'd0;
      FN_GT:   result_code = gt ? 2'd2 : 2'd0;
      FN_LT:   result_code = lt ? 2'd3 : 2'd0;
      FN_CMP3: result_code = eq ? 2'd1 : (gt ? 2'd2 : 2'd3);
      default: result_code = 2'd0;
    endcase
  endfunction

  // Constant-index mux keeps every operand bit in use for any SLICE.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    idx_d   = idx_q;
    out_d   = out_q;
    flag_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.CMP_Enable) begin
          if (bus.ALU_FUN == FN_NOP) begin
            out_d  = 2'd0;
            flag_d = 1'b1;
          end else if (bus.ALU_FUN >= FN_EQ && bus.ALU_FUN <= FN_CMP3) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            a_d     = bus.SIGNED_MODE ? (bus.A ^ MSB_MASK) : bus.A;
            b_d     = bus.SIGNED_MODE ? (bus.B ^ MSB_MASK) : bus.B;
            fun_d   = bus.ALU_FUN;
            idx_d   = IDX_TOP;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (a_sl != b_sl) begin
          out_d   = result_code(fun_q, a_sl > b_sl, a_sl < b_sl);
          flag_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          out_d   = result_code(fun_q, 1'b0, 1'b0);
          flag_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.CMP_OUT  = out_q;
  assign bus.CMP_flag = flag_q;
  assign bus.CMP_Busy = (state_q == SCAN);
endmodule

// File: tb/tb_cmp_unit_seq.sv
// tb/tb_cmp_unit_seq.sv - scoreboard bench for cmp_unit_seq at 16/4
module tb_cmp_unit_seq;
  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  localparam logic [3:0] FN_NOP  = 4'b1000;
  localparam logic [3:0] FN_EQ   = 4'b1001;
  localparam logic [3:0] FN_GT   = 4'b1010;
  localparam logic [3:0] FN_LT   = 4'b1011;
  localparam logic [3:0] FN_CMP3 = 4'b1100;

  typedef struct {
    logic [1:0] out;
    int         lat;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cmp_unit_seq_if #(.WIDTH(WIDTH)) bus();

  cmp_unit_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] hold_out = 2'd0;

  function automatic logic [1:0] model_out(input logic [3:0] fun, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input logic sgn);
    int rel;
    if (sgn) rel = ($signed(a) > $signed(b)) ? 1 : (($signed(a) < $signed(b)) ? -1 : 0);
    else     rel = (a > b) ? 1 : ((a < b) ? -1 : 0);
    case (fun)
      FN_EQ:   return (rel == 0) ? 2'd1 : 2'd0;
      FN_GT:   return (rel > 0)  ? 2'd2 : 2'd0;
      FN_LT:   return (rel < 0)  ? 2'd3 : 2'd0;
      FN_CMP3: return (rel == 0) ? 2'd1 : ((rel > 0) ? 2'd2 : 2'd3);
      default: return 2'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] fun, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    if (fun == FN_NOP) return 0;
    for (int i = NSLICE - 1; i >= 0; i--)
      if (a[i*SLICE +: SLICE] != b[i*SLICE +: SLICE]) return NSLICE - i;
    return NSLICE;
  endfunction

  task automatic issue(input logic [3:0] fun, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic sgn);
    exp_t e;
    bus.ALU_FUN     = fun;
    bus.A           = a;
    bus.B           = b;
    bus.SIGNED_MODE = sgn;
    bus.CMP_Enable  = 1'b1;
    e.out = model_out(fun, a, b, sgn);
    e.lat = model_lat(fun, a, b);
    sb.push_back(e);
  endtask

  // Observes one command from its acceptance edge; k counts edges after acceptance.
  task automatic collect(input bit disturb, output logic [1:0] o, output int lat,
                         output int busy_n, output bit tmo);
    busy_n = 0;
    tmo    = 1'b1;
    lat    = -1;
    o      = 2'bxx;
    @(negedge CLK);
    bus.CMP_Enable = 1'b0;
    for (int k = 0; k <= 2 * NSLICE + 4; k++) begin
      if (k > 0) @(negedge CLK);
      if (bus.CMP_flag) begin
        o   = bus.CMP_OUT;
        lat = k;
        tmo = 1'b0;
        break;
      end
      if (bus.CMP_Busy) busy_n++;
      if (disturb && k == 1) begin
        bus.ALU_FUN    = FN_GT;
        bus.A          = '0;
        bus.CMP_Enable = 1'b1;
      end
      if (disturb && k == 2) begin
        bus.CMP_Enable = 1'b0;
        bus.A          = 16'h1234;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.CMP_Enable = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if (bus.CMP_OUT !== 2'd0) begin n_fail++; $display("FAIL reset_out got %0d want 0", bus.CMP_OUT); end
    n_checks++;
    if (bus.CMP_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag got %b want 0", bus.CMP_flag); end
    n_checks++;
    if (bus.CMP_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.CMP_Busy); end
  endtask

  task automatic test_single(input string name, input logic [3:0] fun, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic sgn, input bit disturb);
    logic [1:0] o;
    int lat, busy_n;
    bit tmo;
    exp_t e;
    issue(fun, a, b, sgn);
    collect(disturb, o, lat, busy_n, tmo);
    e = sb.pop_front();
    n_checks++;
    if (tmo) begin
      n_fail++;
      $display("FAIL %s timeout waiting for CMP_flag", name);
    end else begin
      hold_out = e.out;
      n_checks++;
      if (o !== e.out) begin n_fail++; $display("FAIL %s out got %0d want %0d", name, o, e.out); end
      n_checks++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, lat, e.lat); end
      n_checks++;
      if (busy_n !== e.lat) begin n_fail++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_n, e.lat); end
      @(negedge CLK);
      n_checks++;
      if (bus.CMP_flag !== 1'b0) begin n_fail++; $display("FAIL %s flag_width got %b want 0", name, bus.CMP_flag); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] o;
    int lat, busy_n;
    bit tmo;
    exp_t e;
    issue(FN_CMP3, 16'h1235, 16'h1234, 1'b0);
    collect(1'b0, o, lat, busy_n, tmo);
    e = sb.pop_front();
    n_checks++;
    if (tmo || o !== e.out || lat !== e.lat) begin
      n_fail++;
      $display("FAIL b2b_first out got %0d want %0d lat got %0d want %0d", o, e.out, lat, e.lat);
    end
    issue(FN_LT, 16'h0001, 16'h0002, 1'b0);
    collect(1'b0, o, lat, busy_n, tmo);
    e = sb.pop_front();
    hold_out = e.out;
    n_checks++;
    if (tmo || o !== e.out) begin n_fail++; $display("FAIL b2b_second_out got %0d want %0d", o, e.out); end
    n_checks++;
    if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_second_lat got %0d want %0d", lat, e.lat); end
    @(negedge CLK);
  endtask

  task automatic test_invalid_code();
    int flags = 0, busies = 0;
    bus.ALU_FUN    = 4'b0011;
    bus.A          = 16'h5555;
    bus.B          = 16'h0000;
    bus.CMP_Enable = 1'b1;
    @(negedge CLK);
    bus.CMP_Enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.CMP_flag) flags++;
      if (bus.CMP_Busy) busies++;
      n_checks++;
      if (bus.CMP_OUT !== hold_out) begin
        n_fail++;
        $display("FAIL invalid_hold_out got %0d want %0d", bus.CMP_OUT, hold_out);
      end
      @(negedge CLK);
    end
    n_checks++;
    if (flags != 0 || busies != 0) begin
      n_fail++;
      $display("FAIL invalid_activity flags %0d busy %0d want 0 0", flags, busies);
    end
  endtask

  task automatic test_reset_mid_scan();
    int flags = 0, busies = 0;
    exp_t e;
    issue(FN_EQ, 16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge CLK);
    bus.CMP_Enable = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (bus.CMP_Busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before got %b want 1", bus.CMP_Busy); end
    RST            = 1'b1;
    bus.ALU_FUN    = FN_GT;
    bus.A          = 16'hFFFF;
    bus.B          = 16'h0000;
    bus.CMP_Enable = 1'b1;
    @(negedge CLK);
    RST            = 1'b0;
    bus.CMP_Enable = 1'b0;
    e = sb.pop_front();
    hold_out = 2'd0;
    n_checks++;
    if (bus.CMP_OUT !== 2'd0 || bus.CMP_flag !== 1'b0 || bus.CMP_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs out %0d flag %b busy %b want 0 0 0 (aborted want %0d)",
               bus.CMP_OUT, bus.CMP_flag, bus.CMP_Busy, e.out);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (bus.CMP_flag) flags++;
      if (bus.CMP_Busy) busies++;
    end
    n_checks++;
    if (flags != 0 || busies != 0) begin
      n_fail++;
      $display("FAIL rst_mid_after flags %0d busy %0d want 0 0", flags, busies);
    end
  endtask

  task automatic test_random();
    logic [3:0]       fun;
    logic [WIDTH-1:0] a, b;
    logic             sgn;
    int               s;
    for (int i = 0; i < 24; i++) begin
      fun = 4'(FN_EQ + $urandom_range(0, 3));
      a   = WIDTH'($urandom);
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       b = WIDTH'($urandom);
        1:       b = a;
        default: begin
          s = $urandom_range(0, NSLICE - 1);
          b = a;
          b[s*SLICE +: SLICE] = SLICE'($urandom);
        end
      endcase
      test_single("random", fun, a, b, sgn, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST             = 1'b1;
    bus.A           = '0;
    bus.B           = '0;
    bus.ALU_FUN     = 4'b0000;
    bus.SIGNED_MODE = 1'b0;
    bus.CMP_Enable  = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single("eq_equal", FN_EQ, 16'h1234, 16'h1234, 1'b0, 1'b0);
    test_single("gt_unsigned", FN_GT, 16'h8000, 16'h7FFF, 1'b0, 1'b0);
    test_single("gt_signed", FN_GT, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    test_single("cmp3_signed_less", FN_CMP3, 16'hFFFE, 16'h0003, 1'b1, 1'b0);
    test_back_to_back();
    test_invalid_code();
    test_single("nop", FN_NOP, 16'h1111, 16'h2222, 1'b0, 1'b0);
    test_single("gt_setup", FN_GT, 16'h8000, 16'h7FFF, 1'b0, 1'b0);
    test_reset_mid_scan();
    test_single("ignore_repulse", FN_EQ, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
